// File: rtl/m_store_buffer.sv
// Store buffer between the M stage and the memory bus. Stores are aligned and lane-positioned,
// queued in a small FIFO, and optionally write-combined into the tail entry.
module m_store_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned MERGE  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          st_valid,
    input  logic [1:0]                    st_size,
    input  logic [31:0]                   st_addr,
    input  logic [DATA_W-1:0]             st_data,
    input  logic                          req,
    output logic                          st_ready,
    output logic                          exc_ades,
    output logic [4:0]                    exc_code,
    output logic                          bus_valid,
    output logic [31:0]                   bus_addr,
    output logic [DATA_W/8-1:0]           bus_byteen,
    output logic [DATA_W-1:0]             bus_wdata,
    input  logic                          bus_ready,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] SZ_D = 2'b00;
    localparam logic [1:0] SZ_W = 2'b01;
    localparam logic [1:0] SZ_H = 2'b10;
    localparam logic [1:0] SZ_B = 2'b11;
    localparam logic [4:0] EXC_ADES = 5'd5;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              exc_q, exc_d;
    logic [4:0]        exc_code_q, exc_code_d;

    logic [31:0]       ent_addr_q [DEPTH];
    logic [BE_W-1:0]   ent_be_q   [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];

    logic              size_ok;
    logic              misalign;
    logic [BE_W-1:0]   be_ones;
    logic [DATA_W-1:0] lane_mask;
    logic [OFF_W-1:0]  off;
    logic [OFF_W+2:0]  shamt;
    logic [BE_W-1:0]   new_be;
    logic [DATA_W-1:0] new_data;
    logic [31:0]       new_addr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [DATA_W-1:0] merge_data;
    logic              st_go;
    logic              accept;
    logic              merge_hit;
    logic              do_push;
    logic              do_merge;
    logic              retire;

    // Size decode: unshifted enable pattern, alignment check, legality
    always_comb begin
        size_ok  = 1'b1;
        misalign = 1'b0;
        be_ones  = '0;
        case (st_size)
            SZ_B: be_ones = BE_W'(1);
            SZ_H: begin
                be_ones  = BE_W'(3);
                misalign = st_addr[0];
            end
            SZ_W: begin
                be_ones  = BE_W'(4'hF);
                misalign = |st_addr[1:0];
            end
            SZ_D: begin
                be_ones  = '1;
                misalign = |st_addr[2:0];
                size_ok  = (DATA_W == 64);
            end
            default: be_ones = '0;
        endcase
    end

    // Lane positioning of the incoming store
    always_comb begin
        for (int i = 0; i < int'(BE_W); i++) begin
            lane_mask[8*i +: 8] = {8{be_ones[i]}};
        end
    end

    assign off      = st_addr[OFF_W-1:0];
    assign shamt    = {off, 3'b000};
    assign new_be   = be_ones << off;
    assign new_data = (st_data & lane_mask) << shamt;
    assign new_addr = {st_addr[31:OFF_W], {OFF_W{1'b0}}};
    assign tail_ptr = wr_ptr_q - PTR_W'(1);

    // Newly enabled bytes overwrite the tail, the rest keep their old contents
    always_comb begin
        for (int i = 0; i < int'(BE_W); i++) begin
            merge_data[8*i +: 8] = new_be[i] ? new_data[8*i +: 8] : ent_data_q[tail_ptr][8*i +: 8];
        end
    end

    assign st_ready  = (count_q < CNT_W'(DEPTH));
    assign bus_valid = (count_q != '0);
    assign retire    = bus_valid && bus_ready;
    assign st_go     = st_valid && st_ready && !req;
    assign accept    = st_go && size_ok && !misalign;
    // The head is never a merge target, so at least two entries are required
    assign merge_hit = (MERGE != 0) && (count_q >= CNT_W'(2)) && (ent_addr_q[tail_ptr] == new_addr);
    assign do_merge  = accept && merge_hit;
    assign do_push   = accept && !merge_hit;

    // Next-state logic for pointers, occupancy and exception pulse
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        exc_d      = 1'b0;
        exc_code_d = '0;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (retire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(retire);
        if (st_go && size_ok && misalign) begin
            exc_d      = 1'b1;
            exc_code_d = EXC_ADES;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            exc_q      <= 1'b0;
            exc_code_q <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
        end
    end

    // Entry storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            ent_addr_q[wr_ptr_q] <= new_addr;
            ent_be_q[wr_ptr_q]   <= new_be;
            ent_data_q[wr_ptr_q] <= new_data;
        end else if (do_merge) begin
            ent_be_q[tail_ptr]   <= ent_be_q[tail_ptr] | new_be;
            ent_data_q[tail_ptr] <= merge_data;
        end
    end

    assign bus_addr   = ent_addr_q[rd_ptr_q];
    assign bus_byteen = ent_be_q[rd_ptr_q];
    assign bus_wdata  = ent_data_q[rd_ptr_q];
    assign exc_ades   = exc_q;
    assign exc_code   = exc_code_q;
    assign count      = count_q;

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed bench for m_store_buffer: a 32-bit instance for the main behaviour and a
// 64-bit instance for doubleword and wide-lane cases.
module tb_m_store_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        st_valid, req, bus_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr, st_data;
    logic        st_ready, exc_ades, bus_valid;
    logic [4:0]  exc_code;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_byteen;
    logic [2:0]  count;

    logic        w_st_valid, w_req, w_bus_ready;
    logic [1:0]  w_st_size;
    logic [31:0] w_st_addr;
    logic [63:0] w_st_data;
    logic        w_st_ready, w_exc_ades, w_bus_valid;
    logic [4:0]  w_exc_code;
    logic [31:0] w_bus_addr;
    logic [63:0] w_bus_wdata;
    logic [7:0]  w_bus_byteen;
    logic [2:0]  w_count;

    int checks = 0;
    int errors = 0;

    m_store_buffer #(.DATA_W(32), .DEPTH(4), .MERGE(1)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
        .req(req), .st_ready(st_ready), .exc_ades(exc_ades), .exc_code(exc_code),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_byteen(bus_byteen),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .count(count)
    );

    m_store_buffer #(.DATA_W(64), .DEPTH(4), .MERGE(1)) dut64 (
        .clk(clk), .reset(reset),
        .st_valid(w_st_valid), .st_size(w_st_size), .st_addr(w_st_addr), .st_data(w_st_data),
        .req(w_req), .st_ready(w_st_ready), .exc_ades(w_exc_ades), .exc_code(w_exc_code),
        .bus_valid(w_bus_valid), .bus_addr(w_bus_addr), .bus_byteen(w_bus_byteen),
        .bus_wdata(w_bus_wdata), .bus_ready(w_bus_ready), .count(w_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_size  = sz;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic store64(input logic [1:0] sz, input logic [31:0] a, input logic [63:0] d);
        w_st_valid = 1'b1;
        w_st_size  = sz;
        w_st_addr  = a;
        w_st_data  = d;
    endtask

    initial begin
        reset = 1'b0;
        st_valid = 1'b0; st_size = 2'b01; st_addr = '0; st_data = '0; req = 1'b0; bus_ready = 1'b1;
        w_st_valid = 1'b0; w_st_size = 2'b01; w_st_addr = '0; w_st_data = '0; w_req = 1'b0; w_bus_ready = 1'b0;
        tick();
        tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_bus_valid", 64'(bus_valid), 64'd0);
        check("rst_exc", 64'(exc_ades), 64'd0);
        check("rst_exc_code", 64'(exc_code), 64'd0);
        check("rst_st_ready", 64'(st_ready), 64'd1);
        reset = 1'b1;

        // Byte store, first edge after reset, drains next cycle
        store(2'b11, 32'h0000_1003, 32'h0000_00AB);
        tick();
        st_valid = 1'b0;
        check("sb_valid", 64'(bus_valid), 64'd1);
        check("sb_addr", 64'(bus_addr), 64'h1000);
        check("sb_be", 64'(bus_byteen), 64'b1000);
        check("sb_data", 64'(bus_wdata), 64'hAB00_0000);
        tick();
        check("sb_empty", 64'(count), 64'd0);
        check("sb_empty_valid", 64'(bus_valid), 64'd0);

        // Misaligned half store raises a one-cycle address error
        store(2'b10, 32'h0000_2001, 32'h0000_1234);
        tick();
        st_valid = 1'b0;
        check("ades_count", 64'(count), 64'd0);
        check("ades_pulse", 64'(exc_ades), 64'd1);
        check("ades_code", 64'(exc_code), 64'd5);
        tick();
        check("ades_clear", 64'(exc_ades), 64'd0);
        check("ades_code_clear", 64'(exc_code), 64'd0);

        // Killed stores: no exception, no enqueue
        req = 1'b1;
        store(2'b10, 32'h0000_2001, 32'h0000_1234);
        tick();
        check("kill_no_exc", 64'(exc_ades), 64'd0);
        store(2'b01, 32'h0000_3000, 32'h5555_5555);
        tick();
        st_valid = 1'b0;
        req = 1'b0;
        check("kill_no_enq", 64'(count), 64'd0);

        // Fill to full with the bus stalled, fifth store dropped
        bus_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            store(2'b01, 32'h100 + 32'(4 * k), 32'(k + 1) * 32'h1111_1111);
            tick();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_not_ready", 64'(st_ready), 64'd0);
        store(2'b01, 32'h0000_0200, 32'hFFFF_FFFF);
        tick();
        st_valid = 1'b0;
        check("full_drop", 64'(count), 64'd4);
        check("full_hold_addr", 64'(bus_addr), 64'h100);
        bus_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_addr", 64'(bus_addr), 64'(32'h100 + 32'(4 * k)));
            check("drain_data", 64'(bus_wdata), 64'(32'(k + 1) * 32'h1111_1111));
            tick();
        end
        check("drain_empty", 64'(count), 64'd0);

        // Write-combining into the tail entry
        bus_ready = 1'b0;
        store(2'b01, 32'h0000_0010, 32'hDEAD_BEEF);
        tick();
        store(2'b11, 32'h0000_0020, 32'h0000_0011);
        tick();
        store(2'b11, 32'h0000_0021, 32'h0000_0022);
        tick();
        st_valid = 1'b0;
        check("merge_count", 64'(count), 64'd2);
        bus_ready = 1'b1;
        check("merge_head_addr", 64'(bus_addr), 64'h10);
        check("merge_head_be", 64'(bus_byteen), 64'hF);
        tick();
        check("merge_tail_addr", 64'(bus_addr), 64'h20);
        check("merge_tail_be", 64'(bus_byteen), 64'b0011);
        check("merge_tail_data", 64'(bus_wdata), 64'h0000_2211);
        tick();
        check("merge_empty", 64'(count), 64'd0);

        // The head alone is never merged into
        bus_ready = 1'b0;
        store(2'b11, 32'h0000_0030, 32'h0000_0033);
        tick();
        store(2'b11, 32'h0000_0031, 32'h0000_0044);
        tick();
        st_valid = 1'b0;
        check("nohead_merge_count", 64'(count), 64'd2);
        check("nohead_merge_be", 64'(bus_byteen), 64'b0001);
        bus_ready = 1'b1;
        tick();
        check("nohead_second_be", 64'(bus_byteen), 64'b0010);
        check("nohead_second_data", 64'(bus_wdata), 64'h0000_4400);
        tick();
        check("nohead_empty", 64'(count), 64'd0);

        // Asynchronous reset in the middle of a stalled drain
        bus_ready = 1'b0;
        store(2'b01, 32'h0000_0040, 32'h1);
        tick();
        store(2'b01, 32'h0000_0044, 32'h2);
        tick();
        st_valid = 1'b0;
        check("prerst_count", 64'(count), 64'd2);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus_valid), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        tick();
        reset = 1'b1;

        // 64-bit instance: doubleword, upper word lanes, accept with retire
        store64(2'b00, 32'h0000_0008, 64'h0123_4567_89AB_CDEF);
        tick();
        check("sd_addr", 64'(w_bus_addr), 64'h8);
        check("sd_be", 64'(w_bus_byteen), 64'hFF);
        check("sd_data", w_bus_wdata, 64'h0123_4567_89AB_CDEF);
        store64(2'b01, 32'h0000_0004, 64'h0000_0000_CAFE_BABE);
        tick();
        check("w64_count2", 64'(w_count), 64'd2);
        w_bus_ready = 1'b1;
        store64(2'b01, 32'h0000_0010, 64'h0000_0000_5555_AAAA);
        tick();
        w_st_valid = 1'b0;
        check("w64_acc_ret_count", 64'(w_count), 64'd2);
        check("sw64_addr", 64'(w_bus_addr), 64'h0);
        check("sw64_be", 64'(w_bus_byteen), 64'hF0);
        check("sw64_data", w_bus_wdata, 64'hCAFE_BABE_0000_0000);
        tick();
        check("w64_last_be", 64'(w_bus_byteen), 64'h0F);
        check("w64_last_data", w_bus_wdata, 64'h0000_0000_5555_AAAA);
        check("w64_count1", 64'(w_count), 64'd1);
        tick();
        check("w64_empty", 64'(w_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
